// File: rtl/sar_bit_register_if.sv
// Bus between the SAR datapath and its environment (control, sequencer, DAC, comparator).
// Latency: n/a (wires only).
// Backpressure: none; start is a level request sampled when idle, done is a 1-cycle pulse.
//
// Signals:
//   start      request a conversion (sampled only when idle)
//   phase      one-hot sequencer state: 001 SET, 010 VALIDATE, 100 ADVANCE
//   comp_in    asynchronous comparator output, 1 = Vin >= Vdac
//   seq_enable step strobe to the sequencer
//   seq_clear  1-cycle active-high clear to the sequencer
//   dac_code   trial code to the R2R ladder
//   result     last completed conversion
//   busy       conversion in progress
//   done       1-cycle pulse when result updates
//   phase_err  sticky illegal-phase flag
interface sar_bit_register_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       phase;
  logic             comp_in;
  logic             seq_enable;
  logic             seq_clear;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             phase_err;

  // Environment side: requests conversions, supplies phase and comparator.
  modport master (
    output start, phase, comp_in,
    input  seq_enable, seq_clear, dac_code, result, busy, done, phase_err
  );

  // Datapath side.
  modport slave (
    input  start, phase, comp_in,
    output seq_enable, seq_clear, dac_code, result, busy, done, phase_err
  );
endinterface

// File: rtl/sar_bit_register.sv
// Successive-approximation datapath: trial code, comparator sync, bit index, result; paces the sequencer.
// Latency: 3*WIDTH sequencer steps of DIV clocks; done pulses 3*WIDTH*DIV+1 cycles after start is accepted.
// Backpressure: start is ignored while busy; outputs are never stalled.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low; clears all state, including mid-conversion
//   bus    sar_bit_register_if slave modport (start/phase/comp_in in; sequencer, DAC and status out)
module sar_bit_register #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                clk,
  input  logic                reset,
  sar_bit_register_if.slave   bus
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(DIV);
  localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic             sync1_q, sync1_d;
  logic             comp_s_q, comp_s_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             seq_clear_q, seq_clear_d;
  logic             phase_err_q, phase_err_d;
  logic [WIDTH-1:0] dac_code_q, dac_code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             step;

  // One step every DIV clocks; the gap covers the 2-flop comparator sync and ladder settling.
  assign step = busy_q && (cnt_q == CNT_LAST);

  always_comb begin
    sync1_d     = bus.comp_in;
    comp_s_d    = sync1_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    seq_clear_d = 1'b0;
    phase_err_d = phase_err_q;
    dac_code_d  = dac_code_q;
    result_d    = result_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    if (!busy_q) begin
      if (bus.start) begin
        busy_d      = 1'b1;
        dac_code_d  = '0;
        idx_d       = IDX_TOP;
        cnt_d       = '0;
        phase_err_d = 1'b0;
        seq_clear_d = 1'b1;
      end
    end else begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      if (step) begin
        case (bus.phase)
          3'b001: dac_code_d[idx_q] = 1'b1;
          3'b010: if (!comp_s_q) dac_code_d[idx_q] = 1'b0;
          3'b100: begin
            if (idx_q != '0) begin
              idx_d = idx_q - IW'(1);
            end else begin
              result_d = dac_code_q;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              cnt_d    = '0;
            end
          end
          // Non-one-hot phase: abandon the conversion, keep result and trial code.
          default: begin
            phase_err_d = 1'b1;
            busy_d      = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      comp_s_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      seq_clear_q <= 1'b0;
      phase_err_q <= 1'b0;
      dac_code_q  <= '0;
      result_q    <= '0;
      idx_q       <= IDX_TOP;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      comp_s_q    <= comp_s_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      seq_clear_q <= seq_clear_d;
      phase_err_q <= phase_err_d;
      dac_code_q  <= dac_code_d;
      result_q    <= result_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.seq_enable = step;
  assign bus.seq_clear  = seq_clear_q;
  assign bus.dac_code   = dac_code_q;
  assign bus.result     = result_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.phase_err  = phase_err_q;

endmodule

// File: tb/tb_sar_bit_register.sv
// Bench for sar_bit_register with a one-hot 3-phase sequencer and an ideal comparator.
// Latency: expects done 3*WIDTH*DIV+1 cycles after the start cycle.
// Backpressure: none; start pulses are issued only where the scenario calls for them.
module tb_sar_bit_register;
  localparam int WIDTH = 8;
  localparam int DIV   = 4;
  localparam int LAT   = 3 * WIDTH * DIV + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sar_bit_register_if #(.WIDTH(WIDTH)) bus ();

  sar_bit_register #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] res;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic [7:0] vin = 8'h00;
  logic       comp_ovr_en = 1'b0;
  logic       comp_ovr = 1'b0;
  logic       force_err = 1'b0;
  logic       chk_zero = 1'b0;
  logic [2:0] seq_q;
  int         step_n;

  always @(posedge clk) cyc <= cyc + 1;

  // Sequencer: clears to SET, rotates one-hot on each enable.
  always @(posedge clk) begin
    if (!reset || bus.seq_clear) begin
      seq_q  <= 3'b001;
      step_n <= 0;
    end else if (bus.seq_enable) begin
      seq_q  <= {seq_q[1:0], seq_q[2]};
      step_n <= step_n + 1;
    end
  end

  assign bus.phase   = (force_err && step_n == 4) ? 3'b011 : seq_q;
  assign bus.comp_in = comp_ovr_en ? comp_ovr : (vin >= bus.dac_code);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.result), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("done_result", 32'(bus.result), 32'(e.res));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_dac_code", 32'(bus.dac_code), 32'(e.res));
      end
    end
  end

  // With VIN=0 every VALIDATE must clear the bit just set; seen on the following ADVANCE.
  always @(negedge clk) begin
    if (chk_zero && bus.seq_enable && bus.phase == 3'b100)
      chk("zero_validate", 32'(bus.dac_code), 32'h0);
  end

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic start_now(input logic [7:0] v, input bit push, output int s0);
    vin       = v;
    bus.start = 1'b1;
    s0        = cyc;
    if (push) exp_q.push_back('{s0 + LAT, v});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < budget);
    if (!bus.done) chk(name, 32'(n), 32'(LAT));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk(name, 32'(n), 32'(LAT));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dac_code"},   32'(bus.dac_code),   32'h0);
    chk({tag, "_result"},     32'(bus.result),     32'h0);
    chk({tag, "_busy"},       32'(bus.busy),       32'h0);
    chk({tag, "_done"},       32'(bus.done),       32'h0);
    chk({tag, "_phase_err"},  32'(bus.phase_err),  32'h0);
    chk({tag, "_seq_clear"},  32'(bus.seq_clear),  32'h0);
    chk({tag, "_seq_enable"}, 32'(bus.seq_enable), 32'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int         s0, d;
    logic [7:0] codes [4];
    logic [7:0] a;
    codes = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    bus.start = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_all_zero("reset");

    // Baseline 0xA5 with a start re-issued mid-conversion.
    @(negedge clk);
    start_now(8'hA5, 1'b1, s0);
    chk("seq_clear_c1", 32'(bus.seq_clear), 32'h1);
    chk("busy_c1", 32'(bus.busy), 32'h1);
    @(negedge clk);
    chk("seq_clear_c2", 32'(bus.seq_clear), 32'h0);
    @(negedge clk);
    chk("seq_enable_c3", 32'(bus.seq_enable), 32'h0);
    @(negedge clk);
    chk("seq_enable_c4", 32'(bus.seq_enable), 32'h1);
    wait_until(s0 + 40);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(200, "timeout_a5");
    chk("busy_at_done", 32'(bus.busy), 32'h0);

    // Back-to-back: start in the done cycle.
    start_now(8'h3C, 1'b1, s0);
    wait_until(s0 + 50);
    chk("result_holds_a5", 32'(bus.result), 32'hA5);
    wait_done(200, "timeout_3c");
    @(negedge clk);
    chk("busy_after_3c", 32'(bus.busy), 32'h0);

    // Edge codes.
    foreach (codes[i]) begin
      @(negedge clk);
      chk_zero = (codes[i] == 8'h00);
      start_now(codes[i], 1'b1, s0);
      wait_done(200, "timeout_code");
      chk_zero = 1'b0;
    end

    // Reset mid-conversion.
    @(negedge clk);
    start_now(8'h5A, 1'b0, s0);
    wait_until(s0 + 50);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b1;
    d = done_cnt;
    repeat (150) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt), 32'(d));
    start_now(8'h11, 1'b1, s0);
    wait_done(200, "timeout_11");

    // Illegal phase on the 5th step.
    force_err = 1'b1;
    @(negedge clk);
    start_now(8'h99, 1'b0, s0);
    wait_idle(200, "timeout_perr");
    chk("perr_abort_cycle", 32'(cyc - s0), 32'd21);
    chk("perr_flag", 32'(bus.phase_err), 32'h1);
    chk("perr_busy", 32'(bus.busy), 32'h0);
    chk("perr_result", 32'(bus.result), 32'h11);
    force_err = 1'b0;
    d = done_cnt;
    repeat (120) @(negedge clk);
    chk("perr_no_done", 32'(done_cnt), 32'(d));
    chk("perr_sticky", 32'(bus.phase_err), 32'h1);
    start_now(8'h42, 1'b1, s0);
    chk("perr_cleared", 32'(bus.phase_err), 32'h0);
    wait_done(200, "timeout_42");

    // Comparator sync: value held through cycle V-2 decides; toggle in V-1 must not.
    a = 8'($urandom_range(0, 255));
    comp_ovr_en = 1'b1;
    comp_ovr    = ~a[7];
    @(negedge clk);
    start_now(8'h00, 1'b0, s0);
    exp_q.push_back('{s0 + LAT, a});
    for (int c = 1; c <= 3 * WIDTH * DIV; c++) begin
      if ((c % 12) == 6) begin
        comp_ovr = a[7 - (c - 6) / 12];
      end else if ((c % 12) == 7) begin
        #($urandom_range(1, 4));
        comp_ovr = ~a[7 - (c - 7) / 12];
      end
      @(negedge clk);
    end
    chk("sync_done_seen", 32'(bus.done), 32'h1);
    chk("sync_no_x", 32'($isunknown(bus.dac_code)), 32'h0);
    comp_ovr_en = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
